// File: rtl/z80_bus_target.sv
// Z80 bus responder: decodes CPU memory/I/O cycles in its address windows,
// turns each into one req/ack handshake on the backend port, stretches the
// CPU cycle with wait_n until the ack, and owns one IM2 interrupt source.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no cycle in progress, watching strobes for a window hit or INTA
// REQ    | be_req high, fields latched, CPU held in wait until be_ack
// HOLD   | data/vector presented (or write done); wait for strobes to rise
module z80_bus_target #(
    parameter logic [15:0] MEM_BASE = 16'h8000,
    parameter logic [15:0] MEM_MASK = 16'hC000,
    parameter logic [7:0]  IO_BASE  = 8'h10,
    parameter logic [7:0]  IO_MASK  = 8'hF0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cen,
    input  logic [15:0] A,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_di,
    output logic        cpu_di_en,
    output logic        wait_n,
    output logic        int_n,
    input  logic        irq_in,
    input  logic [7:0]  irq_vector,
    output logic        be_req,
    output logic        be_we,
    output logic        be_io,
    output logic [15:0] be_addr,
    output logic [7:0]  be_wdata,
    input  logic [7:0]  be_rdata,
    input  logic        be_ack
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_cpu_di, w_cpu_di_next;
    logic        r_cpu_di_en, w_cpu_di_en_next;
    logic        r_be_req, w_be_req_next;
    logic        r_be_we, w_be_we_next;
    logic        r_be_io, w_be_io_next;
    logic [15:0] r_be_addr, w_be_addr_next;
    logic [7:0]  r_be_wdata, w_be_wdata_next;
    logic        r_irq_d;
    logic        r_pending, w_pending_next;

    logic w_mem_hit, w_io_hit;
    logic w_mem_rd, w_mem_wr, w_io_rd, w_io_wr, w_inta, w_start;
    logic w_irq_rise, w_inta_accept;

    // Window decode; a zero memory mask claims the whole address space.
    assign w_mem_hit = (MEM_MASK == 16'h0000) || ((A & MEM_MASK) == MEM_BASE);
    assign w_io_hit  = ((A[7:0] & IO_MASK) == IO_BASE);

    // Refresh is excluded from reads via rfsh_n; writes never occur in refresh.
    assign w_mem_rd = !mreq_n && !rd_n && rfsh_n && w_mem_hit;
    assign w_mem_wr = !mreq_n && !wr_n && w_mem_hit;
    assign w_io_rd  = !iorq_n && m1_n && !rd_n && w_io_hit;
    assign w_io_wr  = !iorq_n && m1_n && !wr_n && w_io_hit;
    assign w_inta   = !iorq_n && !m1_n;
    assign w_start  = (w_mem_rd || w_mem_wr || w_io_rd || w_io_wr) && (r_state == S_IDLE);

    assign w_irq_rise = irq_in && !r_irq_d;

    // Wait is combinational so the CPU stalls in the T-state the strobe appears.
    assign wait_n = !(reset_n && (w_start || (r_state == S_REQ)));

    assign cpu_di    = r_cpu_di;
    assign cpu_di_en = r_cpu_di_en;
    assign int_n     = !r_pending;
    assign be_req    = r_be_req;
    assign be_we     = r_be_we;
    assign be_io     = r_be_io;
    assign be_addr   = r_be_addr;
    assign be_wdata  = r_be_wdata;

    // Next-state and registered-output logic.
    always_comb begin
        w_state_next     = r_state;
        w_cpu_di_next    = r_cpu_di;
        w_cpu_di_en_next = r_cpu_di_en;
        w_be_req_next    = r_be_req;
        w_be_we_next     = r_be_we;
        w_be_io_next     = r_be_io;
        w_be_addr_next   = r_be_addr;
        w_be_wdata_next  = r_be_wdata;
        w_inta_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next    = S_REQ;
                    w_be_req_next   = 1'b1;
                    w_be_we_next    = w_mem_wr || w_io_wr;
                    w_be_io_next    = w_io_rd || w_io_wr;
                    w_be_addr_next  = (w_io_rd || w_io_wr) ? {8'h00, A[7:0]} : A;
                    w_be_wdata_next = cpu_dout;
                end else if (w_inta && r_pending) begin
                    w_state_next     = S_HOLD;
                    w_cpu_di_next    = irq_vector;
                    w_cpu_di_en_next = 1'b1;
                    w_inta_accept    = 1'b1;
                end
            end
            S_REQ: begin
                if (be_ack) begin
                    w_state_next  = S_HOLD;
                    w_be_req_next = 1'b0;
                    if (!r_be_we) begin
                        w_cpu_di_next    = be_rdata;
                        w_cpu_di_en_next = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (rd_n && wr_n && (iorq_n || m1_n)) begin
                    w_state_next     = S_IDLE;
                    w_cpu_di_en_next = 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // A new edge in the same cycle as the acknowledge clear wins.
        if (w_irq_rise)
            w_pending_next = 1'b1;
        else if (w_inta_accept)
            w_pending_next = 1'b0;
        else
            w_pending_next = r_pending;
    end

    // State and output registers, advancing only on enabled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cpu_di    <= 8'h00;
            r_cpu_di_en <= 1'b0;
            r_be_req    <= 1'b0;
            r_be_we     <= 1'b0;
            r_be_io     <= 1'b0;
            r_be_addr   <= 16'h0000;
            r_be_wdata  <= 8'h00;
            r_irq_d     <= 1'b0;
            r_pending   <= 1'b0;
        end else if (cen) begin
            r_state     <= w_state_next;
            r_cpu_di    <= w_cpu_di_next;
            r_cpu_di_en <= w_cpu_di_en_next;
            r_be_req    <= w_be_req_next;
            r_be_we     <= w_be_we_next;
            r_be_io     <= w_be_io_next;
            r_be_addr   <= w_be_addr_next;
            r_be_wdata  <= w_be_wdata_next;
            r_irq_d     <= irq_in;
            r_pending   <= w_pending_next;
        end
    end

endmodule

// File: tb/tb_z80_bus_target.sv
// Bench for z80_bus_target: CPU cycle driver, cen-aware backend responder,
// and a queue of expected backend requests checked as be_req rises.
module tb_z80_bus_target;

    logic        clk = 1'b0;
    logic        reset_n, cen;
    logic [15:0] A;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [7:0]  cpu_dout, cpu_di, irq_vector, be_rdata, be_wdata;
    logic        cpu_di_en, wait_n, int_n, irq_in;
    logic        be_req, be_we, be_io, be_ack;
    logic [15:0] be_addr;

    z80_bus_target dut (
        .clk(clk), .reset_n(reset_n), .cen(cen), .A(A),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
        .cpu_dout(cpu_dout), .cpu_di(cpu_di), .cpu_di_en(cpu_di_en), .wait_n(wait_n),
        .int_n(int_n), .irq_in(irq_in), .irq_vector(irq_vector),
        .be_req(be_req), .be_we(be_we), .be_io(be_io), .be_addr(be_addr),
        .be_wdata(be_wdata), .be_rdata(be_rdata), .be_ack(be_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        io;
        logic        wr;
        logic        rfsh;
        logic        tog;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  rdata;
        int          delay;
        logic        hit;
        int          exp_cycles;
    } vec_t;

    int n_total = 0, n_pass = 0;
    logic [25:0] sb[$];
    logic [25:0] cur_exp;
    int req_rises = 0, req_cycles = 0;
    bit stable_bad = 0;
    int ack_delay = 1000;
    logic [7:0] ack_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Request monitor: pops the scoreboard on every rising be_req.
    initial begin
        bit prev = 0;
        forever begin
            @(posedge clk); #1;
            if (be_req && !prev) begin
                req_rises++;
                req_cycles = 0;
                stable_bad = 0;
                if (sb.size() == 0) check("unexpected_req", 1, 0);
                else begin
                    cur_exp = sb.pop_front();
                    check("req_fields", {be_we, be_io, be_addr, be_wdata}, cur_exp);
                end
            end
            if (be_req) begin
                req_cycles++;
                if ({be_we, be_io, be_addr, be_wdata} !== cur_exp) stable_bad = 1;
            end
            prev = be_req;
        end
    end

    // Backend: acks after ack_delay enabled cycles, holds ack until an enabled edge.
    initial begin
        bit ce, seen = 0, done = 0;
        int bcnt = 0;
        be_ack = 0; be_rdata = 8'h00;
        forever begin
            @(posedge clk);
            ce = cen;
            #1;
            if (be_ack) begin
                if (ce) be_ack = 0;
            end else if (be_req && !done) begin
                if (!seen) begin seen = 1; bcnt = 0; end
                else if (ce) bcnt++;
                if (bcnt >= ack_delay - 1) begin be_ack = 1; be_rdata = ack_rdata; done = 1; end
            end
            if (!be_req && !be_ack) begin seen = 0; done = 0; end
        end
    end

    task automatic idle_bus();
        mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1; m1_n = 1;
    endtask

    task automatic bus_cycle(input vec_t v);
        int r0, waited;
        bit saw_low;
        ack_delay = v.delay; ack_rdata = v.rdata;
        r0 = req_rises;
        @(negedge clk);
        cen = 1; A = v.a; cpu_dout = v.d;
        if (v.io) iorq_n = 0; else mreq_n = 0;
        if (v.rfsh) rfsh_n = 0;
        if (v.wr) wr_n = 0; else rd_n = 0;
        if (v.hit) sb.push_back({v.wr, v.io, (v.io ? {8'h00, v.a[7:0]} : v.a), v.d});
        #1 check("wait_on_strobe", wait_n, !v.hit);
        if (v.hit) begin
            waited = 0;
            while (!wait_n && waited < 200) begin
                @(negedge clk);
                if (v.tog) cen = ~cen;
                waited++;
                #1;
            end
            check("wait_release_in_budget", waited < 200, 1);
            cen = 1;
            check("req_cycles", req_cycles, v.exp_cycles);
            check("req_fields_stable", stable_bad, 0);
        end else begin
            saw_low = 0;
            repeat (4) begin @(negedge clk); #1; if (!wait_n) saw_low = 1; end
            check("miss_no_wait", saw_low, 0);
        end
        check("di_en_after_cycle", cpu_di_en, v.hit && !v.wr);
        if (v.hit && !v.wr) check("read_data", cpu_di, v.rdata);
        repeat (2) @(negedge clk);
        #1 check("one_req_per_cycle", req_rises - r0, v.hit ? 1 : 0);
        @(negedge clk); idle_bus();
        @(negedge clk); #1;
        check("di_en_cleared", cpu_di_en, 0);
        if (v.hit && !v.wr) check("di_held_after_release", cpu_di, v.rdata);
    endtask

    task automatic inta_cycle(input logic [7:0] vec, input logic irq_val, input logic exp_en, input logic exp_int_n);
        @(negedge clk);
        irq_vector = vec; irq_in = irq_val; m1_n = 0; iorq_n = 0;
        #1 check("inta_no_wait", wait_n, 1);
        @(negedge clk); #1;
        check("inta_di_en", cpu_di_en, exp_en);
        if (exp_en) check("inta_vector", cpu_di, vec);
        check("int_n_after_inta", int_n, exp_int_n);
        m1_n = 1; iorq_n = 1;
        @(negedge clk); #1 check("inta_di_en_cleared", cpu_di_en, 0);
    endtask

    vec_t vecs[9];
    vec_t rv;

    initial begin
        int r0, waited;
        //            io  wr  rf  tog  a        d      rdata  dly  hit cyc
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,16'h8123,8'h00,8'h5A,3,1'b1,3};
        vecs[1] = '{1'b1,1'b1,1'b0,1'b0,16'hAB15,8'hC3,8'h00,1,1'b1,1};
        vecs[2] = '{1'b0,1'b0,1'b1,1'b0,16'h8000,8'h00,8'hFF,1,1'b0,0};
        vecs[3] = '{1'b0,1'b0,1'b0,1'b0,16'h4000,8'h00,8'hFF,1,1'b0,0};
        vecs[4] = '{1'b0,1'b1,1'b0,1'b0,16'hBFFF,8'h77,8'h00,2,1'b1,2};
        vecs[5] = '{1'b1,1'b0,1'b0,1'b0,16'h001F,8'h00,8'h9E,4,1'b1,4};
        vecs[6] = '{1'b1,1'b0,1'b0,1'b0,16'h1234,8'h00,8'hFF,1,1'b0,0};
        vecs[7] = '{1'b0,1'b0,1'b0,1'b0,16'hC000,8'h00,8'hFF,1,1'b0,0};
        vecs[8] = '{1'b0,1'b0,1'b0,1'b1,16'h8ABC,8'h00,8'h3C,2,1'b1,4};

        reset_n = 0; cen = 1; A = 16'h0000; cpu_dout = 8'h00;
        irq_in = 0; irq_vector = 8'h00; idle_bus();
        repeat (3) @(negedge clk);
        #1;
        check("rst_outputs", {cpu_di, cpu_di_en, wait_n, int_n, be_req}, {8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
        check("rst_be_fields", {be_we, be_io, be_addr, be_wdata}, 26'h0);
        reset_n = 1;

        for (int i = 0; i < 9; i++) bus_cycle(vecs[i]);

        // Interrupt source and acknowledge.
        r0 = req_rises;
        @(negedge clk); irq_in = 1;
        #1 check("int_n_before_edge_sampled", int_n, 1);
        @(negedge clk); #1 check("int_n_asserted", int_n, 0);
        inta_cycle(8'hE8, 1'b1, 1'b1, 1'b1);
        inta_cycle(8'hE8, 1'b1, 1'b0, 1'b1);
        @(negedge clk); irq_in = 0;
        @(negedge clk); irq_in = 1;
        @(negedge clk); #1 check("int_n_second_edge", int_n, 0);
        irq_in = 0;
        @(negedge clk);
        inta_cycle(8'h5D, 1'b1, 1'b1, 1'b0);
        inta_cycle(8'hA2, 1'b1, 1'b1, 1'b1);
        check("inta_no_backend", req_rises - r0, 0);

        // Reset while a request is outstanding.
        ack_delay = 1000;
        @(negedge clk);
        A = 16'h8004; cpu_dout = 8'h11; mreq_n = 0; wr_n = 0;
        sb.push_back({1'b1, 1'b0, 16'h8004, 8'h11});
        waited = 0;
        while (!be_req && waited < 10) begin @(negedge clk); waited++; end
        check("req_before_reset", be_req, 1);
        reset_n = 0;
        #1;
        check("reset_drops_req", be_req, 0);
        check("reset_wait_n", wait_n, 1);
        check("reset_di", {cpu_di_en, cpu_di}, 9'h000);
        @(negedge clk); idle_bus();
        @(negedge clk); reset_n = 1;
        rv = '{1'b0,1'b0,1'b0,1'b0,16'h8010,8'h00,8'h42,2,1'b1,2};
        bus_cycle(rv);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
